pipeline_hazard_controller: RTL

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

---
 rtl/pipeline_hazard_controller.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_controller.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_controller
//
// Hazard and stall/flush control for the five-stage pipeline.
//   * Combinational (same-cycle) write-enable, flush and forward-select
//     outputs, chosen with priority FREEZE > FLUSH > STALL > RUN.
//   * Registered ctrl_state holding the action taken in the previous cycle.
//   * Wrapping stall/flush performance counters, `MAX_LENGTH bits wide.
//
// Build option:
//   FORWARDING_EN  defined   -> EX-stage operand forwarding, load-use stalls only
//                  undefined -> no forwarding, stall on any EX or MEM producer
// ---------------------------------------------------------------------------

`ifndef MAX_LENGTH
`define MAX_LENGTH 8
`endif

module pipeline_hazard_controller (
    input  logic                   clk,
    input  logic                   reset,

    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic                   id_uses_rt,

    input  logic [4:0]             idex_rs,
    input  logic [4:0]             idex_rt,
    input  logic [4:0]             idex_rd,
    input  logic                   idex_reg_write,
    input  logic                   idex_mem_read,

    input  logic [4:0]             exmem_rd,
    input  logic [4:0]             memwb_rd,
    input  logic                   exmem_reg_write,
    input  logic                   memwb_reg_write,

    input  logic                   branch_taken,
    input  logic                   dmem_busy,

    output logic                   pc_write_enabled,
    output logic                   ifid_write_enabled,
    output logic                   pipe_write_enabled,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic [1:0]             forward_a_sel,
    output logic [1:0]             forward_b_sel,
    output logic [1:0]             ctrl_state,
    output logic [`MAX_LENGTH-1:0] stall_count,
    output logic [`MAX_LENGTH-1:0] flush_count
);

    localparam int unsigned CW = `MAX_LENGTH;

    typedef enum logic [1:0] {
        ACT_RUN    = 2'd0,
        ACT_STALL  = 2'd1,
        ACT_FREEZE = 2'd2,
        ACT_FLUSH  = 2'd3
    } action_t;

    action_t        action;
    action_t        state_q;
    logic           hazard;
    logic [1:0]     fwd_a;
    logic [1:0]     fwd_b;
    logic [CW-1:0]  stall_q;
    logic [CW-1:0]  flush_q;

    // True when a writing producer's nonzero destination feeds an ID source.
    function automatic logic id_src_match(input logic [4:0] rd, input logic we,
                                          input logic [4:0] rs, input logic [4:0] rt,
                                          input logic uses_rt);
        return we && (rd != 5'd0) && ((rd == rs) || (uses_rt && (rd == rt)));
    endfunction

`ifdef FORWARDING_EN
    // Forward select for one EX operand: the younger EX/MEM result wins over MEM/WB.
    function automatic logic [1:0] fwd_select(input logic [4:0] src,
                                              input logic [4:0] ex_rd, input logic ex_we,
                                              input logic [4:0] wb_rd, input logic wb_we);
        if (ex_we && (ex_rd != 5'd0) && (ex_rd == src))
            return 2'd2;
        else if (wb_we && (wb_rd != 5'd0) && (wb_rd == src))
            return 2'd1;
        else
            return 2'd0;
    endfunction

    // Only a load in EX cannot be forwarded in time; everything else is bypassed.
    always_comb begin
        hazard = id_src_match(idex_rd, idex_reg_write & idex_mem_read,
                              id_rs, id_rt, id_uses_rt);
        fwd_a  = fwd_select(idex_rs, exmem_rd, exmem_reg_write, memwb_rd, memwb_reg_write);
        fwd_b  = fwd_select(idex_rt, exmem_rd, exmem_reg_write, memwb_rd, memwb_reg_write);
    end
`else
    // Operand sources only matter for forwarding; fold them into a sink here.
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{idex_rs, idex_rt, memwb_rd, memwb_reg_write, idex_mem_read};

    // Without bypassing, any pending EX or MEM writer stalls; WB writes before ID reads.
    always_comb begin
        hazard = id_src_match(idex_rd, idex_reg_write, id_rs, id_rt, id_uses_rt)
               | id_src_match(exmem_rd, exmem_reg_write, id_rs, id_rt, id_uses_rt);
        fwd_a  = 2'd0;
        fwd_b  = 2'd0;
    end
`endif

    // Pick this cycle's action by priority; reset forces RUN.
    always_comb begin
        action = ACT_RUN;
        if (reset)
            action = ACT_RUN;
        else if (dmem_busy)
            action = ACT_FREEZE;
        else if (branch_taken)
            action = ACT_FLUSH;
        else if (hazard)
            action = ACT_STALL;
    end

    // Decode the chosen action into pipeline enables, flushes and selectors.
    always_comb begin
        pc_write_enabled   = 1'b1;
        ifid_write_enabled = 1'b1;
        pipe_write_enabled = 1'b1;
        ifid_flush         = 1'b0;
        idex_flush         = 1'b0;
        forward_a_sel      = reset ? 2'd0 : fwd_a;
        forward_b_sel      = reset ? 2'd0 : fwd_b;
        case (action)
            ACT_FREEZE: begin
                pc_write_enabled   = 1'b0;
                ifid_write_enabled = 1'b0;
                pipe_write_enabled = 1'b0;
            end
            ACT_FLUSH: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end
            ACT_STALL: begin
                pc_write_enabled   = 1'b0;
                ifid_write_enabled = 1'b0;
                idex_flush         = 1'b1;
            end
            default: ;
        endcase
    end

    // Record the action taken and count stall/freeze and flush cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ACT_RUN;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= action;
            if ((action == ACT_STALL) || (action == ACT_FREEZE))
                stall_q <= stall_q + CW'(1);
            if (action == ACT_FLUSH)
                flush_q <= flush_q + CW'(1);
        end
    end

    assign ctrl_state  = state_q;
    assign stall_count = stall_q;
    assign flush_count = flush_q;

endmodule
